// File: rtl/slurm16_memory_responder.sv
// rtl/slurm16_memory_responder.sv - two-port arbitrated responder over a byte-maskable 16-bit word RAM
// Port 0 (CPU) and port 1 (DMA) share one access per cycle; reads return one cycle after the grant.
module slurm16_memory_responder #(
  parameter int BITS         = 16,
  parameter int ADDRESS_BITS = 16,
  parameter int DEPTH_LOG2   = 12,
  parameter int CPU_PRIORITY = 1,
  parameter int MAX_WAIT     = 7
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [ADDRESS_BITS-1:0] i_p0_address,
  input  logic [BITS-1:0]         i_p0_out,
  input  logic                    i_p0_valid,
  input  logic                    i_p0_wr,
  input  logic [1:0]              i_p0_wr_mask,
  output logic                    o_p0_ready,
  output logic                    o_p0_rd_valid,
  input  logic [ADDRESS_BITS-1:0] i_p1_address,
  input  logic [BITS-1:0]         i_p1_out,
  input  logic                    i_p1_valid,
  input  logic                    i_p1_wr,
  input  logic [1:0]              i_p1_wr_mask,
  output logic                    o_p1_ready,
  output logic                    o_p1_rd_valid,
  output logic [BITS-1:0]         o_rd_data
);

  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  logic [BITS-1:0]       r_mem [0:(2**DEPTH_LOG2)-1];
  logic                  r_last_grant;
  logic [WAIT_W-1:0]     r_wait_cnt;
  logic                  r_p0_ready;
  logic                  r_p1_ready;
  logic                  r_p0_rd_pend;
  logic                  r_p1_rd_pend;
  logic                  r_p0_rd_valid;
  logic                  r_p1_rd_valid;
  logic [DEPTH_LOG2-1:0] r_rd_index;
  logic [BITS-1:0]       r_rd_data;

  logic                  w_grant0;
  logic                  w_grant1;
  logic                  w_access;
  logic                  w_wr;
  logic [1:0]            w_mask;
  logic [BITS-1:0]       w_wdata;
  logic [DEPTH_LOG2-1:0] w_index;
  logic                  w_unused_addr;

  // Address bit 0 and bits above the RAM depth alias away.
  assign w_unused_addr = ^{i_p0_address[0], i_p0_address[ADDRESS_BITS-1:DEPTH_LOG2+1],
                           i_p1_address[0], i_p1_address[ADDRESS_BITS-1:DEPTH_LOG2+1]};

  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (!i_rst) begin
      if (i_p0_valid && i_p1_valid) begin
        if (CPU_PRIORITY != 0) begin
          w_grant1 = (r_wait_cnt == WAIT_LIMIT);
        end else begin
          w_grant1 = (r_last_grant == 1'b0);
        end
        w_grant0 = !w_grant1;
      end else begin
        w_grant0 = i_p0_valid;
        w_grant1 = i_p1_valid;
      end
    end
  end

  assign w_access = w_grant0 || w_grant1;
  assign w_wr     = w_grant1 ? i_p1_wr      : i_p0_wr;
  assign w_mask   = w_grant1 ? i_p1_wr_mask : i_p0_wr_mask;
  assign w_wdata  = w_grant1 ? i_p1_out     : i_p0_out;
  assign w_index  = w_grant1 ? i_p1_address[DEPTH_LOG2:1] : i_p0_address[DEPTH_LOG2:1];

  always_ff @(posedge i_clk) begin
    if (w_access && w_wr) begin
      if (w_mask[0]) r_mem[w_index][7:0]  <= w_wdata[7:0];
      if (w_mask[1]) r_mem[w_index][15:8] <= w_wdata[15:8];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last_grant  <= 1'b1;
      r_wait_cnt    <= '0;
      r_p0_ready    <= 1'b0;
      r_p1_ready    <= 1'b0;
      r_p0_rd_pend  <= 1'b0;
      r_p1_rd_pend  <= 1'b0;
      r_p0_rd_valid <= 1'b0;
      r_p1_rd_valid <= 1'b0;
      r_rd_index    <= '0;
      r_rd_data     <= '0;
    end else begin
      r_p0_ready    <= w_grant0;
      r_p1_ready    <= w_grant1;
      r_p0_rd_pend  <= w_grant0 && !i_p0_wr;
      r_p1_rd_pend  <= w_grant1 && !i_p1_wr;
      r_p0_rd_valid <= r_p0_rd_pend;
      r_p1_rd_valid <= r_p1_rd_pend;
      if (w_access) r_last_grant <= w_grant1;
      if (w_grant1 || !i_p1_valid) begin
        r_wait_cnt <= '0;
      end else if (r_wait_cnt != WAIT_LIMIT) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      if (w_access && !w_wr) r_rd_index <= w_index;
      // No write can land between the grant edge and this edge, so the word is the granted one.
      if (r_p0_rd_pend || r_p1_rd_pend) r_rd_data <= r_mem[r_rd_index];
    end
  end

  assign o_p0_ready    = r_p0_ready;
  assign o_p1_ready    = r_p1_ready;
  assign o_p0_rd_valid = r_p0_rd_valid;
  assign o_p1_rd_valid = r_p1_rd_valid;
  assign o_rd_data     = r_rd_data;

endmodule

// File: tb/tb_slurm16_memory_responder.sv
// tb/tb_slurm16_memory_responder.sv - randomized model-checked bench for slurm16_memory_responder
// A priority-mode instance is checked every cycle against a word-array model; a round-robin instance checks alternation.
module tb_slurm16_memory_responder;

  localparam int MAIN_PRIO = 1;
  localparam int MAIN_WAIT = 7;

  logic clk, rst, chk_en;
  logic [15:0] p0_address, p0_out, p1_address, p1_out;
  logic p0_valid, p0_wr, p1_valid, p1_wr;
  logic [1:0] p0_wr_mask, p1_wr_mask;
  logic o_p0_ready, o_p0_rd_valid, o_p1_ready, o_p1_rd_valid;
  logic [15:0] o_rd_data;
  logic rr_p0_valid, rr_p1_valid;
  logic rr_p0_ready, rr_p0_rd_valid, rr_p1_ready, rr_p1_rd_valid;
  logic [15:0] rr_rd_data;

  int n_checks = 0;
  int n_fail = 0;

  logic [15:0] mem_m [0:4095];
  logic m_rdy0, m_rdy1, m_rdv0, m_rdv1, m_pend0, m_pend1, m_w;
  logic [15:0] m_rd, m_pend_data, m_a, m_d;
  logic [1:0] m_mk;
  int m_last, m_wait, m_g, m_idx;

  slurm16_memory_responder #(.CPU_PRIORITY(MAIN_PRIO), .MAX_WAIT(MAIN_WAIT)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_p0_address(p0_address), .i_p0_out(p0_out), .i_p0_valid(p0_valid), .i_p0_wr(p0_wr),
    .i_p0_wr_mask(p0_wr_mask), .o_p0_ready(o_p0_ready), .o_p0_rd_valid(o_p0_rd_valid),
    .i_p1_address(p1_address), .i_p1_out(p1_out), .i_p1_valid(p1_valid), .i_p1_wr(p1_wr),
    .i_p1_wr_mask(p1_wr_mask), .o_p1_ready(o_p1_ready), .o_p1_rd_valid(o_p1_rd_valid),
    .o_rd_data(o_rd_data)
  );

  slurm16_memory_responder #(.CPU_PRIORITY(0), .MAX_WAIT(MAIN_WAIT)) dut_rr (
    .i_clk(clk), .i_rst(rst),
    .i_p0_address(16'h0010), .i_p0_out(16'h0000), .i_p0_valid(rr_p0_valid), .i_p0_wr(1'b0),
    .i_p0_wr_mask(2'b00), .o_p0_ready(rr_p0_ready), .o_p0_rd_valid(rr_p0_rd_valid),
    .i_p1_address(16'h0020), .i_p1_out(16'h0000), .i_p1_valid(rr_p1_valid), .i_p1_wr(1'b0),
    .i_p1_wr_mask(2'b00), .o_p1_ready(rr_p1_ready), .o_p1_rd_valid(rr_p1_rd_valid),
    .o_rd_data(rr_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference: one access per cycle chosen by the arbitration rules, read data one cycle later.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rdy0 = 0; m_rdy1 = 0; m_rdv0 = 0; m_rdv1 = 0; m_pend0 = 0; m_pend1 = 0;
      m_rd = 16'h0; m_last = 1; m_wait = 0;
    end else begin
      m_rdv0 = m_pend0;
      m_rdv1 = m_pend1;
      if (m_pend0 || m_pend1) m_rd = m_pend_data;
      if (p0_valid && p1_valid) m_g = (MAIN_PRIO != 0) ? ((m_wait == MAIN_WAIT) ? 1 : 0) : ((m_last == 1) ? 0 : 1);
      else if (p0_valid) m_g = 0;
      else if (p1_valid) m_g = 1;
      else m_g = -1;
      m_rdy0 = (m_g == 0);
      m_rdy1 = (m_g == 1);
      m_pend0 = (m_g == 0) && !p0_wr;
      m_pend1 = (m_g == 1) && !p1_wr;
      if (m_g >= 0) begin
        m_a = (m_g == 1) ? p1_address : p0_address;
        m_w = (m_g == 1) ? p1_wr : p0_wr;
        m_mk = (m_g == 1) ? p1_wr_mask : p0_wr_mask;
        m_d = (m_g == 1) ? p1_out : p0_out;
        m_idx = (int'(m_a) / 2) % 4096;
        if (m_w) begin
          if (m_mk[0]) mem_m[m_idx][7:0] = m_d[7:0];
          if (m_mk[1]) mem_m[m_idx][15:8] = m_d[15:8];
        end else begin
          m_pend_data = mem_m[m_idx];
        end
        m_last = m_g;
      end
      if (m_g == 1 || !p1_valid) m_wait = 0;
      else if (m_wait < MAIN_WAIT) m_wait++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("p0_ready", o_p0_ready, m_rdy0);
      check("p1_ready", o_p1_ready, m_rdy1);
      check("p0_rd_valid", o_p0_rd_valid, m_rdv0);
      check("p1_rd_valid", o_p1_rd_valid, m_rdv1);
      check("rd_data", o_rd_data, m_rd);
      check("ready_exclusive", o_p0_ready & o_p1_ready, 0);
      check("rr_ready_exclusive", rr_p0_ready & rr_p1_ready, 0);
    end
  end

  function automatic logic [15:0] pool_addr(input int k);
    int idx;
    idx = (k * 263 + 5) % 4096;
    return 16'(($urandom & 32'h0000_E001) | (idx << 1));
  endfunction

  task automatic set_req(input int port, input logic [15:0] a, input logic w, input logic [1:0] m, input logic [15:0] d);
    if (port == 0) begin
      p0_address = a; p0_wr = w; p0_wr_mask = m; p0_out = d; p0_valid = 1'b1;
    end else begin
      p1_address = a; p1_wr = w; p1_wr_mask = m; p1_out = d; p1_valid = 1'b1;
    end
  endtask

  task automatic drop(input int port);
    if (port == 0) p0_valid = 1'b0;
    else p1_valid = 1'b0;
  endtask

  task automatic rand_req(input int port);
    set_req(port, pool_addr($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), 16'($urandom));
  endtask

  task automatic req(input int port, input logic [15:0] a, input logic w, input logic [1:0] m, input logic [15:0] d);
    bit got;
    got = 0;
    set_req(port, a, w, m, d);
    for (int c = 0; c < 40 && !got; c++) begin
      @(posedge clk); #1;
      got = (port == 0) ? m_rdy0 : m_rdy1;
    end
    check("req_grant", (port == 0) ? o_p0_ready : o_p1_ready, 1);
    drop(port);
  endtask

  task automatic read_check(input string name, input int port, input logic [15:0] a, input logic [15:0] expv);
    req(port, a, 1'b0, 2'b11, 16'h0000);
    @(posedge clk); #1;
    check({name, "_rd_valid"}, (port == 0) ? o_p0_rd_valid : o_p1_rd_valid, 1);
    check({name, "_ready_dropped"}, (port == 0) ? o_p0_ready : o_p1_ready, 0);
    check({name, "_data"}, o_rd_data, expv);
  endtask

  initial begin
    int p1_at;
    bit got;
    rst = 0; chk_en = 0;
    p0_address = 0; p0_out = 0; p0_valid = 0; p0_wr = 0; p0_wr_mask = 0;
    p1_address = 0; p1_out = 0; p1_valid = 0; p1_wr = 0; p1_wr_mask = 0;
    rr_p0_valid = 1; rr_p1_valid = 1;
    #1 rst = 1; chk_en = 1;
    #1;
    check("rst_p0_ready", o_p0_ready, 0);
    check("rst_p1_ready", o_p1_ready, 0);
    check("rst_p0_rd_valid", o_p0_rd_valid, 0);
    check("rst_p1_rd_valid", o_p1_rd_valid, 0);
    check("rst_rd_data", o_rd_data, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // Round-robin instance: first tie to port 0, then strict alternation.
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      check("rr_p0_grant", rr_p0_ready, (k % 2 == 0) ? 1 : 0);
      check("rr_p1_grant", rr_p1_ready, (k % 2 == 0) ? 0 : 1);
    end
    rr_p0_valid = 0; rr_p1_valid = 0;

    req(0, 16'h0100, 1'b1, 2'b11, 16'hBEEF);
    read_check("t1_beef", 0, 16'h0100, 16'hBEEF);
    req(0, 16'h0100, 1'b1, 2'b01, 16'h1234);
    read_check("t2_low_byte", 0, 16'h0100, 16'hBE34);
    req(0, 16'h0100, 1'b1, 2'b00, 16'hFFFF);
    read_check("t2_mask_none", 1, 16'h0101, 16'hBE34);
    req(0, 16'h2002, 1'b1, 2'b11, 16'hA5A5);
    read_check("t5_alias", 0, 16'h0002, 16'hA5A5);

    for (int k = 0; k < 16; k++) req(k % 2, pool_addr(k), 1'b1, 2'b11, 16'($urandom));

    // Port 0 streams reads while port 1 waits: port 1 wins on its 8th waiting cycle.
    set_req(0, pool_addr(0), 1'b0, 2'b11, 16'h0);
    set_req(1, pool_addr(1), 1'b0, 2'b11, 16'h0);
    p1_at = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (o_p1_ready && p1_at == 0) p1_at = c;
      if (c == 9) check("t4_p0_resumes", o_p0_ready, 1);
      if (m_rdy1) drop(1);
      if (m_rdy0) set_req(0, pool_addr(c % 16), 1'b0, 2'b11, 16'h0);
    end
    check("t4_p1_grant_cycle", p1_at, 8);
    drop(0);
    repeat (2) @(posedge clk);
    #1;

    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      if (!p0_valid || m_rdy0) begin
        if ($urandom_range(0, 9) < (p0_valid ? 6 : 4)) rand_req(0);
        else drop(0);
      end
      if (!p1_valid || m_rdy1) begin
        if ($urandom_range(0, 9) < (p1_valid ? 5 : 3)) rand_req(1);
        else drop(1);
      end
    end
    drop(0); drop(1);
    repeat (3) @(posedge clk);
    #1;

    // Reset while port 1 holds its grant; port 1 keeps valid and is granted again after release.
    set_req(1, pool_addr(3), 1'b0, 2'b11, 16'h0);
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(posedge clk); #1;
      got = m_rdy1;
    end
    check("t6_p1_ready_before_rst", o_p1_ready, 1);
    rst = 1;
    #1;
    check("t6_p1_ready_rst", o_p1_ready, 0);
    check("t6_p0_ready_rst", o_p0_ready, 0);
    check("t6_p0_rd_valid_rst", o_p0_rd_valid, 0);
    check("t6_p1_rd_valid_rst", o_p1_rd_valid, 0);
    check("t6_rd_data_rst", o_rd_data, 0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    check("t6_regrant", o_p1_ready, 1);
    drop(1);
    repeat (3) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
